// File: rtl/mp_addsub_seq.sv
// Sequential multi-precision adder/subtractor: one ADDER_WIDTH chunk per cycle, LSB chunk first.
// Define MP_ADDSUB_LATCH_OPS_EN to capture iOpA/iOpB on the start edge instead of reading them live.
module mp_addsub_seq #(
    parameter int OPERAND_WIDTH = 512,
    parameter int ADDER_WIDTH   = 128
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iStart,
    input  logic                     iCommand,
    input  logic [OPERAND_WIDTH-1:0] iOpA,
    input  logic [OPERAND_WIDTH-1:0] iOpB,
    output logic [OPERAND_WIDTH:0]   oRes,
    output logic                     oDone
);

    localparam int NCHUNK = OPERAND_WIDTH / ADDER_WIDTH;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE,
        HOLD
    } state_t;

    state_t                   state;
    logic                     cmd;
    logic                     carry;
    logic [CNT_W-1:0]         chunkCnt;
    logic [OPERAND_WIDTH-1:0] acc;
    logic [OPERAND_WIDTH-1:0] accNext;
    logic [ADDER_WIDTH-1:0]   chunkA;
    logic [ADDER_WIDTH-1:0]   chunkB;
    logic [ADDER_WIDTH:0]     chunkSum;

    // Subtraction is A + ~B + 1: the initial carry supplies the +1.
    function automatic logic [ADDER_WIDTH:0] addChunk(
        input logic [ADDER_WIDTH-1:0] a,
        input logic [ADDER_WIDTH-1:0] b,
        input logic                   invB,
        input logic                   cin
    );
        logic [ADDER_WIDTH-1:0] bEff;
        bEff = invB ? ~b : b;
        return {1'b0, a} + {1'b0, bEff} + {{ADDER_WIDTH{1'b0}}, cin};
    endfunction

`ifdef MP_ADDSUB_LATCH_OPS_EN
    logic [OPERAND_WIDTH-1:0] opA;
    logic [OPERAND_WIDTH-1:0] opB;

    always_comb begin
        chunkA = opA[int'(chunkCnt) * ADDER_WIDTH +: ADDER_WIDTH];
        chunkB = opB[int'(chunkCnt) * ADDER_WIDTH +: ADDER_WIDTH];
    end
`else
    always_comb begin
        chunkA = iOpA[int'(chunkCnt) * ADDER_WIDTH +: ADDER_WIDTH];
        chunkB = iOpB[int'(chunkCnt) * ADDER_WIDTH +: ADDER_WIDTH];
    end
`endif

    assign chunkSum = addChunk(chunkA, chunkB, cmd, carry);

    // Accumulator fills from the top and shifts down, so chunk 0 lands at the bottom after NCHUNK cycles.
    generate
        if (NCHUNK > 1) begin : gAccShift
            assign accNext = {chunkSum[ADDER_WIDTH-1:0], acc[OPERAND_WIDTH-1:ADDER_WIDTH]};
        end else begin : gAccSingle
            assign accNext = chunkSum[ADDER_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            oRes     <= '0;
            oDone    <= 1'b0;
            cmd      <= 1'b0;
            carry    <= 1'b0;
            chunkCnt <= '0;
            acc      <= '0;
`ifdef MP_ADDSUB_LATCH_OPS_EN
            opA      <= '0;
            opB      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        cmd      <= iCommand;
                        carry    <= iCommand;
                        chunkCnt <= '0;
`ifdef MP_ADDSUB_LATCH_OPS_EN
                        opA      <= iOpA;
                        opB      <= iOpB;
`endif
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc   <= accNext;
                    carry <= chunkSum[ADDER_WIDTH];
                    if (chunkCnt == LAST_CHUNK) begin
                        chunkCnt <= '0;
                        oRes     <= {chunkSum[ADDER_WIDTH], accNext};
                        oDone    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        chunkCnt <= chunkCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    oDone <= 1'b0;
                    // A start still held from the previous request must drop before a new one is taken.
                    if (!iStart) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: directed vector table, handshake/reset sequences, random ops vs model.
module tb_mp_addsub_seq;

    localparam int OW     = 512;
    localparam int AW     = 128;
    localparam int NCHUNK = OW / AW;
    localparam int LAT    = NCHUNK + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cmdIn;
    logic [OW-1:0] opA;
    logic [OW-1:0] opB;
    logic [OW:0]   res;
    logic          done;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    mp_addsub_seq #(
        .OPERAND_WIDTH(OW),
        .ADDER_WIDTH  (AW)
    ) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iStart  (start),
        .iCommand(cmdIn),
        .iOpA    (opA),
        .iOpB    (opB),
        .oRes    (res),
        .oDone   (done)
    );

    typedef struct {
        string         name;
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          cmd;
        logic [OW:0]   exp;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string name, input logic [OW:0] act, input logic [OW:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on whole operands.
    function automatic logic [OW:0] model(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sub);
        logic [OW:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b};
        end else begin
            r[OW-1:0] = a - b;
            r[OW]     = (a >= b);
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from the accepting edge to the oDone cycle (0 on timeout).
    task automatic waitDone(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick;
        end
    endtask

    task automatic runOp(input string name, input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input logic sub, input logic [OW:0] exp);
        int lat;
        start = 1'b0;
        tick;
        tick;
        opA   = a;
        opB   = b;
        cmdIn = sub;
        start = 1'b1;
        tick;
        start = 1'b0;
        cmdIn = ~sub;
        waitDone(lat);
        check({name, "_lat"}, (OW+1)'(lat), (OW+1)'(LAT));
        check({name, "_res"}, res, exp);
        if (lat != 0) begin
            tick;
            check({name, "_pulse"}, (OW+1)'(done), '0);
        end
    endtask

    initial begin
        logic [OW-1:0] ra;
        logic [OW-1:0] rb;
        logic          rc;
        int            pulses;
        int            lat;

        tv[0] = '{"add_cout",   {OW{1'b1}},          OW'(1),        1'b0, {1'b1, {OW{1'b0}}}};
        tv[1] = '{"add_chunk",  OW'({AW{1'b1}}),     OW'(1),        1'b0, (OW+1)'(1) << AW};
        tv[2] = '{"add_msb",    OW'(1) << (OW-1),    OW'(1) << (OW-1), 1'b0, {1'b1, {OW{1'b0}}}};
        tv[3] = '{"sub_borrow", OW'(5),              OW'(7),        1'b1, {1'b0, {(OW-1){1'b1}}, 1'b0}};
        tv[4] = '{"sub_equal",  OW'(16'hDEAD),       OW'(16'hDEAD), 1'b1, {1'b1, {OW{1'b0}}}};
        tv[5] = '{"add_small",  OW'(3),              OW'(4),        1'b0, (OW+1)'(7)};
        tv[6] = '{"sub_zero",   '0,                  '0,            1'b1, {1'b1, {OW{1'b0}}}};
        tv[7] = '{"sub_neg1",   '0,                  OW'(1),        1'b1, {1'b0, {OW{1'b1}}}};

        rst   = 1'b1;
        start = 1'b0;
        cmdIn = 1'b0;
        opA   = '0;
        opB   = '0;
        repeat (3) tick;
        check("rst_res", res, '0);
        check("rst_done", (OW+1)'(done), '0);
        rst = 1'b0;
        tick;
        check("idle_done", (OW+1)'(done), '0);

        for (int i = 0; i < 8; i++) begin
            runOp(tv[i].name, tv[i].a, tv[i].b, tv[i].cmd, tv[i].exp);
        end

        // Start held high for 20 cycles gives one completion; cmd flip after acceptance is ignored.
        start = 1'b0;
        tick;
        tick;
        opA    = OW'(100);
        opB    = OW'(1);
        cmdIn  = 1'b0;
        start  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            cmdIn = 1'b1;
            if (done) pulses++;
        end
        check("hold_pulses", (OW+1)'(pulses), (OW+1)'(1));
        check("hold_res", res, (OW+1)'(101));
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
        waitDone(lat);
        check("restart_lat", (OW+1)'(lat), (OW+1)'(LAT));
        check("restart_res", res, {1'b1, OW'(99)});
        tick;
        tick;
        check("restart_hold", (OW+1)'(done), '0);
        start = 1'b0;

        // Reset during the second CALC cycle aborts without oDone.
        tick;
        tick;
        opA   = OW'(9);
        opB   = OW'(2);
        cmdIn = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_res", res, '0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) pulses++;
            tick;
        end
        check("abort_pulses", (OW+1)'(pulses), '0);
        check("abort_res_held", res, '0);
        runOp("after_abort", OW'(3), OW'(4), 1'b0, (OW+1)'(7));

`ifdef MP_ADDSUB_LATCH_OPS_EN
        start = 1'b0;
        tick;
        tick;
        opA   = OW'(10);
        opB   = OW'(3);
        cmdIn = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        waitDone(lat);
        check("latch_lat", (OW+1)'(lat), (OW+1)'(LAT));
        check("latch_res", res, (OW+1)'(13));
`endif

        for (int n = 0; n < 30; n++) begin
            for (int w = 0; w < OW / 32; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra + OW'($urandom_range(0, 3)) - OW'(2);
                default: ;
            endcase
            rc = 1'($urandom_range(0, 1));
            runOp($sformatf("rand%0d", n), ra, rb, rc, model(ra, rb, rc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Sequential multi-precision add/subtract engine that consumes the two operand buffers assembled by the UART front end and returns an (OPERAND_WIDTH+1)-bit result. It processes operands in ADDER_WIDTH-bit chunks, least-significant chunk first, one chunk per cycle, with a registered carry between chunks. It sits directly downstream of the UART command/operand receive logic and upstream of the result transmit logic. It is started and finished through a level-start / pulse-done handshake.

## Interface
- OPERAND_WIDTH, 512, operand width in bits; must be an integer multiple of ADDER_WIDTH
- ADDER_WIDTH, 128, chunk width processed per cycle; NCHUNK = OPERAND_WIDTH/ADDER_WIDTH ≥ 1
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iStart  in  1  start request, level; accepted only in IDLE
- iCommand  in  1  0 = add (A+B), 1 = subtract (A−B); sampled with accepted iStart
- iOpA  in  OPERAND_WIDTH  operand A
- iOpB  in  OPERAND_WIDTH  operand B
- oRes  out  OPERAND_WIDTH+1  result; bit OPERAND_WIDTH = final carry-out
- oDone  out  1  one-cycle pulse, oRes valid

## Operation
- States: IDLE, CALC, DONE, HOLD.
- IDLE: oDone=0. If iStart=1: latch command; carry ← iCommand; chunk counter ← 0; go CALC. Otherwise stay.
- CALC: chunk i = A[i] + (cmd ? ~B[i] : B[i]) + carry, where X[i] = X[i*ADDER_WIDTH +: ADDER_WIDTH]. Store sum chunk i in an internal accumulator; carry ← chunk carry-out; counter increments. After chunk NCHUNK−1: go DONE.
- Entering DONE: oRes ← {final carry, accumulator}.
- DONE: oDone=1 for exactly this cycle. Go HOLD.
- HOLD: stay while iStart=1; go IDLE when iStart=0. A start held high across completion never retriggers.
- Add: oRes = A+B exactly (OPERAND_WIDTH+1 bits).
- Subtract: oRes[OPERAND_WIDTH-1:0] = (A−B) mod 2^OPERAND_WIDTH; oRes[OPERAND_WIDTH] = 1 iff A ≥ B (no borrow).
- iCommand changes after acceptance are ignored.
- oRes is updated only on the edge entering DONE. It is stable from then until the next completion.
- Reset (any state, including mid-CALC): state → IDLE; oRes = 0; oDone = 0; carry, counter and accumulator = 0. The aborted operation produces no oDone.

## Timing
- Start sampled high in IDLE at edge T0 → CALC occupies cycles T0+1 … T0+NCHUNK. oDone=1 in cycle T0+NCHUNK+1.
- Default 512/128: NCHUNK=4; oDone 5 cycles after start is sampled.
- Minimum start-to-start spacing: NCHUNK+3 cycles (CALC×NCHUNK, DONE, HOLD with iStart low, IDLE).
- Critical path: one ADDER_WIDTH-bit adder plus carry mux; there is no full-width adder.
- Reset values: oRes = 0, oDone = 0, state IDLE.

## Configuration
- MP_ADDSUB_LATCH_OPS_EN defined: iOpA/iOpB are captured into internal registers on the accepting edge. Later input changes have no effect on the running operation.
- Undefined: no operand registers. Each CALC cycle reads its chunk directly from iOpA/iOpB. The caller must hold both operands stable from the start edge until oDone. Results under changing inputs are undefined.
- Handshake, latency and result are identical in both builds when operands are held stable.

## Test plan
- Add carry-out: A = 2^512−1, B = 1, cmd=0 → oRes = 2^512 (bit 512 = 1, rest 0); oDone exactly 5 cycles after start is sampled.
- Chunk-boundary carry: A = 2^128−1, B = 1, cmd=0 → oRes = 2^128, bit 512 = 0. Separately, A = B = 2^511 → oRes = 2^512.
- Subtract with borrow: A = 5, B = 7, cmd=1 → oRes[511:0] = 2^512−2, oRes[512] = 0. Separately, A = B = 0xDEAD → oRes = 2^512 (zero difference, no-borrow bit set).
- Handshake: hold iStart=1 for 20 cycles → exactly one oDone. Drop iStart for 1 cycle, then raise it → second oDone after NCHUNK+1 cycles.
- Reset mid-operation: assert iRst in the 2nd CALC cycle → no oDone, oRes = 0. A fresh start then completes correctly (3 + 4 → 7).
- Latch build (MP_ADDSUB_LATCH_OPS_EN): start with A = 10, B = 3, then set A = B = 0 the next cycle → oRes = 13.
